radix5_frame_loader: RTL and testbench

- Serial-to-parallel input stage of the radix-5 FFT datapath. Sits directly upstream of the radix-5 butterfly and its constant-multiplier (K-coefficient) pipelines.
- Accepts one complex IEEE-754 single-precision sample per cycle and assembles frames of 5 points (x0..x4). Presents each frame in parallel to the butterfly for one cycle.
- Generates a valid/frame-index pair delayed to line up with the butterfly's fixed pipeline latency, so downstream stages can capture results.

---
 rtl/radix5_frame_loader.sv | 150 +++++++++++++++
 tb/tb_radix5_frame_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/radix5_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : radix5_frame_loader
//  Description : Serial-to-parallel front end of the radix-5 FFT butterfly.
//                Collects five complex single-precision samples into one
//                frame, presents it for one cycle, and provides a valid/index
//                pair delayed by the butterfly pipeline latency.
//  Revision    : 1.0  initial release
// ============================================================================
module radix5_frame_loader #(
    parameter int BF_LAT = 12,
    parameter int IDXW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     in_re,
    input  logic [31:0]     in_img,
    input  logic            in_sof,
    input  logic            flush,
    output logic [31:0]     x0_re,
    output logic [31:0]     x1_re,
    output logic [31:0]     x2_re,
    output logic [31:0]     x3_re,
    output logic [31:0]     x4_re,
    output logic [31:0]     x0_img,
    output logic [31:0]     x1_img,
    output logic [31:0]     x2_img,
    output logic [31:0]     x3_img,
    output logic [31:0]     x4_img,
    output logic            out_valid,
    output logic [IDXW-1:0] frame_idx,
    output logic            bf_valid,
    output logic [IDXW-1:0] bf_frame_idx,
    output logic            sof_err
);

    // Slot index at which the incoming sample completes a frame.
    localparam logic [2:0] c_last_slot = 3'd4;

    // Staging: samples packed as {re, img}, never altered.
    logic [63:0]     r_slot [4];
    logic [2:0]      r_cnt;
    logic [IDXW-1:0] r_frame_cnt;

    logic [31:0]     r_x_re  [5];
    logic [31:0]     r_x_img [5];
    logic            r_out_valid;
    logic [IDXW-1:0] r_frame_idx;
    logic            r_sof_err;

    // Delay line, stage 0 in the low bits.
    logic [BF_LAT-1:0]      r_dly_v;
    logic [BF_LAT*IDXW-1:0] r_dly_i;

    logic [63:0] w_sample;
    logic        w_sof_restart;

    assign w_sample      = {in_re, in_img};
    // A start-of-frame arriving with a partial frame staged restarts collection.
    assign w_sof_restart = in_sof && (r_cnt != 3'd0);

    // Frame assembly: staging writes, frame load, sof restart and flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= '0;
            end
            for (int i = 0; i < 5; i++) begin
                r_x_re[i]  <= '0;
                r_x_img[i] <= '0;
            end
            r_cnt       <= '0;
            r_frame_cnt <= '0;
            r_out_valid <= 1'b0;
            r_frame_idx <= '0;
            r_sof_err   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_sof_err   <= 1'b0;
            if (flush) begin
                // Staging contents are left stale; cnt alone defines validity.
                r_cnt <= '0;
            end else if (in_valid) begin
                if (w_sof_restart) begin
                    r_slot[0] <= w_sample;
                    r_cnt     <= 3'd1;
                    r_sof_err <= 1'b1;
                end else if (r_cnt == c_last_slot) begin
                    for (int i = 0; i < 4; i++) begin
                        r_x_re[i]  <= r_slot[i][63:32];
                        r_x_img[i] <= r_slot[i][31:0];
                    end
                    r_x_re[4]   <= in_re;
                    r_x_img[4]  <= in_img;
                    r_out_valid <= 1'b1;
                    r_frame_idx <= r_frame_cnt;
                    r_frame_cnt <= r_frame_cnt + {{(IDXW-1){1'b0}}, 1'b1};
                    r_cnt       <= '0;
                end else begin
                    r_slot[r_cnt[1:0]] <= w_sample;
                    r_cnt              <= r_cnt + 3'd1;
                end
            end
        end
    end

    // Free-running shift of {out_valid, frame_idx}; never stalled.
    generate
        if (BF_LAT == 1) begin : g_dly_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dly_v <= '0;
                    r_dly_i <= '0;
                end else begin
                    r_dly_v <= r_out_valid;
                    r_dly_i <= r_frame_idx;
                end
            end
        end else begin : g_dly_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dly_v <= '0;
                    r_dly_i <= '0;
                end else begin
                    r_dly_v <= {r_dly_v[BF_LAT-2:0], r_out_valid};
                    r_dly_i <= {r_dly_i[(BF_LAT-1)*IDXW-1:0], r_frame_idx};
                end
            end
        end
    endgenerate

    assign x0_re        = r_x_re[0];
    assign x1_re        = r_x_re[1];
    assign x2_re        = r_x_re[2];
    assign x3_re        = r_x_re[3];
    assign x4_re        = r_x_re[4];
    assign x0_img       = r_x_img[0];
    assign x1_img       = r_x_img[1];
    assign x2_img       = r_x_img[2];
    assign x3_img       = r_x_img[3];
    assign x4_img       = r_x_img[4];
    assign out_valid    = r_out_valid;
    assign frame_idx    = r_frame_idx;
    assign sof_err      = r_sof_err;
    assign bf_valid     = r_dly_v[BF_LAT-1];
    assign bf_frame_idx = r_dly_i[BF_LAT*IDXW-1 -: IDXW];

endmodule
`default_nettype wire

// File: tb/tb_radix5_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_radix5_frame_loader
//  Description : Directed self-checking bench for radix5_frame_loader.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_radix5_frame_loader;

    localparam int BF_LAT = 12;
    localparam int IDXW   = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic [31:0]     in_re = '0;
    logic [31:0]     in_img = '0;
    logic            in_sof = 1'b0;
    logic            flush = 1'b0;
    logic [31:0]     x0_re, x1_re, x2_re, x3_re, x4_re;
    logic [31:0]     x0_img, x1_img, x2_img, x3_img, x4_img;
    logic            out_valid, bf_valid, sof_err;
    logic [IDXW-1:0] frame_idx, bf_frame_idx;

    logic [31:0] xr [5];
    logic [31:0] xi [5];
    assign xr[0] = x0_re;  assign xr[1] = x1_re;  assign xr[2] = x2_re;
    assign xr[3] = x3_re;  assign xr[4] = x4_re;
    assign xi[0] = x0_img; assign xi[1] = x1_img; assign xi[2] = x2_img;
    assign xi[3] = x3_img; assign xi[4] = x4_img;

    int total = 0;
    int bad   = 0;

    radix5_frame_loader #(.BF_LAT(BF_LAT), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_img(in_img),
        .in_sof(in_sof), .flush(flush),
        .x0_re(x0_re), .x1_re(x1_re), .x2_re(x2_re), .x3_re(x3_re), .x4_re(x4_re),
        .x0_img(x0_img), .x1_img(x1_img), .x2_img(x2_img), .x3_img(x3_img), .x4_img(x4_img),
        .out_valid(out_valid), .frame_idx(frame_idx), .bf_valid(bf_valid),
        .bf_frame_idx(bf_frame_idx), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] re, input logic [31:0] im,
                        input logic v, input logic sof, input logic fl);
        in_re = re; in_img = im; in_valid = v; in_sof = sof; flush = fl;
        tick();
        in_valid = 1'b0; in_sof = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; flush = 1'b0;
        in_re = '0; in_img = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (bf_valid !== 1'b0) begin bad++; $display("FAIL reset_bf_valid got=%b exp=0", bf_valid); end
        total++; if (sof_err !== 1'b0) begin bad++; $display("FAIL reset_sof_err got=%b exp=0", sof_err); end
        total++; if (frame_idx !== 8'd0) begin bad++; $display("FAIL reset_frame_idx got=%0d exp=0", frame_idx); end
        total++; if (bf_frame_idx !== 8'd0) begin bad++; $display("FAIL reset_bf_idx got=%0d exp=0", bf_frame_idx); end
        for (int i = 0; i < 5; i++) begin
            total++; if (xr[i] !== 32'd0 || xi[i] !== 32'd0) begin
                bad++; $display("FAIL reset_x%0d got=%h/%h exp=0/0", i, xr[i], xi[i]);
            end
        end
    endtask

    // 1.0 .. 10.0 as IEEE-754 single; imaginary part is the negated value.
    task automatic test_basic();
        logic [31:0] tab [10];
        logic        ev;
        logic        eb;
        tab = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            if (k <= 10) send(tab[k-1], tab[k-1] | 32'h80000000, 1'b1, 1'b0, 1'b0);
            else         send(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            ev = (k == 5) || (k == 10);
            eb = (k == 17) || (k == 22);
            total++; if (out_valid !== ev) begin bad++; $display("FAIL basic_out_valid k=%0d got=%b exp=%b", k, out_valid, ev); end
            total++; if (bf_valid !== eb) begin bad++; $display("FAIL basic_bf_valid k=%0d got=%b exp=%b", k, bf_valid, eb); end
            if (k == 5) begin
                total++; if (frame_idx !== 8'd0) begin bad++; $display("FAIL basic_idx0 got=%0d exp=0", frame_idx); end
                for (int i = 0; i < 5; i++) begin
                    total++; if (xr[i] !== tab[i] || xi[i] !== (tab[i] | 32'h80000000)) begin
                        bad++; $display("FAIL basic_f0_x%0d got=%h/%h exp=%h/%h", i, xr[i], xi[i], tab[i], tab[i] | 32'h80000000);
                    end
                end
            end
            if (k == 10) begin
                total++; if (frame_idx !== 8'd1) begin bad++; $display("FAIL basic_idx1 got=%0d exp=1", frame_idx); end
                total++; if (x0_re !== 32'h40C00000) begin bad++; $display("FAIL basic_f1_x0 got=%h exp=40c00000", x0_re); end
                total++; if (x4_re !== 32'h41200000 || x4_img !== 32'hC1200000) begin
                    bad++; $display("FAIL basic_f1_x4 got=%h/%h exp=41200000/c1200000", x4_re, x4_img);
                end
            end
            if (k == 17) begin
                total++; if (bf_frame_idx !== 8'd0) begin bad++; $display("FAIL basic_bf_idx0 got=%0d exp=0", bf_frame_idx); end
            end
            if (k == 22) begin
                total++; if (bf_frame_idx !== 8'd1) begin bad++; $display("FAIL basic_bf_idx1 got=%0d exp=1", bf_frame_idx); end
            end
        end
    endtask

    task automatic test_gaps();
        logic [8:0] pat;
        int         acc [5];
        pat = 9'b1_0110_1001;   // bit j is in_valid of step j: 1,0,0,1,0,1,1,0,1
        acc = '{0, 3, 5, 6, 8};
        do_reset();
        for (int j = 0; j < 9; j++) begin
            send(32'h10000000 + j, 32'h20000000 + j, pat[j], 1'b0, 1'b0);
            total++; if (out_valid !== (j == 8)) begin bad++; $display("FAIL gaps_out_valid j=%0d got=%b exp=%b", j, out_valid, j == 8); end
        end
        for (int i = 0; i < 5; i++) begin
            total++; if (xr[i] !== 32'h10000000 + acc[i] || xi[i] !== 32'h20000000 + acc[i]) begin
                bad++; $display("FAIL gaps_x%0d got=%h/%h exp=%h/%h", i, xr[i], xi[i], 32'h10000000 + acc[i], 32'h20000000 + acc[i]);
            end
        end
        total++; if (frame_idx !== 8'd0) begin bad++; $display("FAIL gaps_idx got=%0d exp=0", frame_idx); end
    endtask

    task automatic test_sof();
        do_reset();
        for (int j = 0; j < 3; j++) begin
            send(32'h30000001 + j, 32'h0, 1'b1, 1'b0, 1'b0);
            total++; if (sof_err !== 1'b0) begin bad++; $display("FAIL sof_pre_err j=%0d got=%b exp=0", j, sof_err); end
        end
        send(32'h3A000000, 32'h3B000000, 1'b1, 1'b1, 1'b0);
        total++; if (sof_err !== 1'b1) begin bad++; $display("FAIL sof_err_pulse got=%b exp=1", sof_err); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sof_out_valid_a got=%b exp=0", out_valid); end
        for (int j = 0; j < 4; j++) begin
            send(32'h30000010 + j, 32'h40000010 + j, 1'b1, 1'b0, 1'b0);
            total++; if (sof_err !== 1'b0) begin bad++; $display("FAIL sof_post_err j=%0d got=%b exp=0", j, sof_err); end
            total++; if (out_valid !== (j == 3)) begin bad++; $display("FAIL sof_out_valid j=%0d got=%b exp=%b", j, out_valid, j == 3); end
        end
        total++; if (x0_re !== 32'h3A000000 || x0_img !== 32'h3B000000) begin
            bad++; $display("FAIL sof_x0 got=%h/%h exp=3a000000/3b000000", x0_re, x0_img);
        end
        for (int i = 1; i < 5; i++) begin
            total++; if (xr[i] !== 32'h30000010 + i - 1) begin bad++; $display("FAIL sof_x%0d got=%h exp=%h", i, xr[i], 32'h30000010 + i - 1); end
        end
        total++; if (frame_idx !== 8'd0) begin bad++; $display("FAIL sof_idx got=%0d exp=0", frame_idx); end
    endtask

    task automatic test_flush();
        do_reset();
        send(32'h70000001, 32'h0, 1'b1, 1'b0, 1'b0);
        send(32'h70000002, 32'h0, 1'b1, 1'b0, 1'b0);
        send(32'h7B000000, 32'h7B000001, 1'b1, 1'b1, 1'b1);   // B with flush (and sof)
        total++; if (sof_err !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_cycle got=err%b/ov%b exp=0/0", sof_err, out_valid);
        end
        for (int j = 0; j < 5; j++) begin
            send(32'h7C000000 + j, 32'h7D000000 + j, 1'b1, 1'b0, 1'b0);
            total++; if (out_valid !== (j == 4)) begin bad++; $display("FAIL flush_out_valid j=%0d got=%b exp=%b", j, out_valid, j == 4); end
            total++; if (sof_err !== 1'b0) begin bad++; $display("FAIL flush_sof_err j=%0d got=%b exp=0", j, sof_err); end
        end
        for (int i = 0; i < 5; i++) begin
            total++; if (xr[i] !== 32'h7C000000 + i || xi[i] !== 32'h7D000000 + i) begin
                bad++; $display("FAIL flush_x%0d got=%h/%h exp=%h/%h", i, xr[i], xi[i], 32'h7C000000 + i, 32'h7D000000 + i);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ei;
        do_reset();
        for (int k = 1; k <= 1285; k++) begin
            send(k, ~k, 1'b1, 1'b0, 1'b0);
            total++; if (out_valid !== ((k % 5) == 0)) begin
                bad++; $display("FAIL wrap_out_valid k=%0d got=%b exp=%b", k, out_valid, (k % 5) == 0);
            end
            if ((k % 5) == 0) begin
                ei = 8'((k / 5) - 1);
                total++; if (frame_idx !== ei) begin bad++; $display("FAIL wrap_idx k=%0d got=%0d exp=%0d", k, frame_idx, ei); end
            end
        end
        total++; if (frame_idx !== 8'd0) begin bad++; $display("FAIL wrap_after_255 got=%0d exp=0", frame_idx); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int j = 0; j < 7; j++) send(32'h50000000 + j, 32'h51000000 + j, 1'b1, 1'b0, 1'b0);
        send(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        send(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        total++; if (x0_re !== 32'h50000000) begin bad++; $display("FAIL arst_pre_x0 got=%h exp=50000000", x0_re); end
        #2 rst = 1'b1;
        #1;
        total++; if (x0_re !== 32'd0 || x4_img !== 32'd0) begin bad++; $display("FAIL arst_x got=%h/%h exp=0/0", x0_re, x4_img); end
        total++; if (out_valid !== 1'b0 || bf_valid !== 1'b0 || sof_err !== 1'b0) begin
            bad++; $display("FAIL arst_flags got=%b%b%b exp=000", out_valid, bf_valid, sof_err);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            send(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            total++; if (bf_valid !== 1'b0) begin bad++; $display("FAIL arst_stale_bf j=%0d got=%b exp=0", j, bf_valid); end
        end
        for (int j = 0; j < 5; j++) begin
            send(32'h60000000 + j, 32'h61000000 + j, 1'b1, 1'b0, 1'b0);
            total++; if (out_valid !== (j == 4)) begin bad++; $display("FAIL arst_out_valid j=%0d got=%b exp=%b", j, out_valid, j == 4); end
        end
        total++; if (frame_idx !== 8'd0) begin bad++; $display("FAIL arst_idx got=%0d exp=0", frame_idx); end
        total++; if (x0_re !== 32'h60000000 || x4_re !== 32'h60000004) begin
            bad++; $display("FAIL arst_frame got=%h/%h exp=60000000/60000004", x0_re, x4_re);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_sof();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
